// File: rtl/spi_master_param.sv
// spi_master_param: SPI master with run-time CPOL/CPHA, SCLK divider,
// DATA_W-bit MSB-first frames and one-hot chip selects with optional hold.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W = 8,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              hold_cs,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_E = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]       edg_q, edg_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                hold_q, hold_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;

  logic                tx_ready_d;
  logic                busy_d;
  logic                rx_valid_d;
  logic [DATA_W-1:0]   rx_data_d;
  logic                sclk_d;
  logic                mosi_d;
  logic [NUM_CS-1:0]   cs_n_d;

  logic half_done;
  logic last_edge;

  assign half_done = (cnt_q == div_q);
  assign last_edge = (edg_q == LAST_E);

  function automatic logic [NUM_CS-1:0] cs_decode(
    input logic [CSW-1:0] sel
  );
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CSW'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  // State and datapath registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      edg_q    <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      hold_q   <= 1'b0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edg_q    <= edg_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      hold_q   <= hold_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      tx_ready <= tx_ready_d;
      busy     <= busy_d;
      rx_valid <= rx_valid_d;
      rx_data  <= rx_data_d;
      spi_sclk <= sclk_d;
      spi_mosi <= mosi_d;
      spi_cs_n <= cs_n_d;
    end
  end

  // Next state: each non-idle state lasts whole half-periods.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tx_valid) state_d = S_SETUP;
      S_SETUP: if (half_done) state_d = S_SHIFT;
      S_SHIFT: if (half_done && last_edge) state_d = S_HOLD;
      S_HOLD:  if (half_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of outputs, shift registers and half-period timers.
  always_comb begin
    cnt_d      = half_done ? '0 : cnt_q + 1'b1;
    edg_d      = edg_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    hold_d     = hold_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data;
    sclk_d     = spi_sclk;
    mosi_d     = spi_mosi;
    cs_n_d     = spi_cs_n;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        edg_d = '0;
        if (tx_valid) begin
          div_d   = clk_div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          hold_d  = hold_cs;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          sclk_d  = cpol;
          mosi_d  = tx_data[DATA_W-1];
          cs_n_d  = cs_decode(cs_sel);
        end
      end
      S_SETUP: begin
      end
      S_SHIFT: begin
        if (half_done) begin
          edg_d  = edg_q + 1'b1;
          sclk_d = ~spi_sclk;
          // edg_q even means this is a leading edge
          if (edg_q[0] == cpha_q) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], spi_miso};
          end else if (cpha_q) begin
            mosi_d  = tx_sr_q[DATA_W-1];
            tx_sr_d = tx_sr_q << 1;
          end else if (!last_edge) begin
            mosi_d  = tx_sr_q[DATA_W-2];
            tx_sr_d = tx_sr_q << 1;
          end
        end
      end
      S_HOLD: begin
        if (half_done) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sr_q;
          mosi_d     = 1'b0;
          if (!hold_q) cs_n_d = '1;
        end
      end
      default: begin
      end
    endcase
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: random frames against a behavioural SPI slave,
// a cycle-level waveform model and an rx scoreboard.
module tb_spi_master_param;

  localparam int W   = 8;
  localparam int NCS = 4;
  localparam int DW  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           tx_valid;
  logic           tx_ready;
  logic [W-1:0]   tx_data;
  logic [1:0]     cs_sel;
  logic           cpol;
  logic           cpha;
  logic [DW-1:0]  clk_div;
  logic           hold_cs;
  logic           rx_valid;
  logic [W-1:0]   rx_data;
  logic           busy;
  logic           spi_sclk;
  logic           spi_mosi;
  logic           spi_miso;
  logic [NCS-1:0] spi_cs_n;

  logic           lb = 1'b1;
  logic [W-1:0]   resp = '0;
  logic           miso_s = 1'b0;

  assign spi_miso = lb ? spi_mosi : miso_s;

  always #5 clk = ~clk;

  spi_master_param #(
    .DATA_W(W),
    .NUM_CS(NCS),
    .DIV_W(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .cs_sel(cs_sel),
    .cpol(cpol),
    .cpha(cpha),
    .clk_div(clk_div),
    .hold_cs(hold_cs),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .busy(busy),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    int           t;
  } exp_t;
  exp_t sq[$];

  // inputs as seen by the upcoming clock edge
  logic           r_q = 1'b1;
  logic           v_q = 1'b0;
  logic [W-1:0]   d_q = '0;
  logic           pol_q = 1'b0;
  logic           pha_q = 1'b0;
  logic [DW-1:0]  dv_q = '0;
  logic [1:0]     sel_q = '0;
  logic           hd_q = 1'b0;
  logic [W-1:0]   rs_q = '0;
  logic           lb_q = 1'b1;

  // frame model
  logic           pend = 1'b0;
  int             p_e0 = 0;
  int             p_h = 1;
  int             p_end = 0;
  logic           p_hold = 1'b0;
  logic           p_cpol = 1'b0;
  logic           p_cpha = 1'b0;
  logic [W-1:0]   p_data = '0;
  logic [W-1:0]   p_exp = '0;
  logic           exp_idle = 1'b0;
  logic [NCS-1:0] exp_cs = '1;
  logic [W-1:0]   exp_rxd = '0;
  int             acc_cnt = 0;
  logic           m_was;
  int             m_t, m_ne, m_idx, m_lead;

  // slave model
  logic           s_act = 1'b0;
  logic           s_cpol = 1'b0;
  logic           s_cpha = 1'b0;
  logic           s_prev = 1'b0;
  int             s_edges = 0;
  int             s_ns = 0;
  int             s_bit = 0;
  logic [W-1:0]   s_rx = '0;
  logic [W-1:0]   s_resp = '0;
  logic [W-1:0]   s_txexp = '0;
  logic           s_lead;

  // Reference model: frame timing, waveform and SPI slave.
  always @(negedge clk) begin
    if (r_q) begin
      pend = 1'b0;
      exp_cs = '1;
      exp_idle = 1'b0;
      exp_rxd = '0;
      s_act = 1'b0;
      s_edges = 0;
      sq.delete();
    end else begin
      m_was = pend;
      if (pend && cyc == p_end) begin
        pend = 1'b0;
        exp_rxd = p_exp;
        if (!p_hold) exp_cs = '1;
      end
      if (!m_was && v_q) begin
        pend = 1'b1;
        p_e0 = cyc;
        p_h = int'(dv_q) + 1;
        p_end = cyc + (2 * W + 2) * p_h;
        p_hold = hd_q;
        p_cpol = pol_q;
        p_cpha = pha_q;
        p_data = d_q;
        p_exp = lb_q ? d_q : rs_q;
        exp_idle = pol_q;
        exp_cs = '1;
        exp_cs[sel_q] = 1'b0;
        sq.push_back('{d: p_exp, t: p_end});
        acc_cnt++;
        s_act = 1'b1;
        s_cpol = pol_q;
        s_cpha = pha_q;
        s_prev = pol_q;
        s_edges = 0;
        s_ns = 0;
        s_bit = W - 1;
        s_rx = '0;
        s_resp = rs_q;
        s_txexp = d_q;
        miso_s = rs_q[W-1];
      end
    end

    if (s_act && spi_sclk !== s_prev) begin
      s_prev = spi_sclk;
      s_edges++;
      s_lead = (spi_sclk != s_cpol);
      if (s_lead != s_cpha) begin
        s_rx = {s_rx[W-2:0], spi_mosi};
        s_ns++;
        if (s_ns == W) begin
          chk("slave_rx", s_rx, s_txexp);
          s_act = 1'b0;
        end
      end else if (s_cpha) begin
        miso_s = s_resp[s_bit];
        s_bit--;
      end else if (s_edges < 2 * W) begin
        s_bit--;
        miso_s = s_resp[s_bit];
      end
    end

    chk("busy", busy, pend);
    chk("tx_ready", tx_ready, !pend);
    chk("cs_n", spi_cs_n, exp_cs);
    chk("cs_onehot", $countones(~spi_cs_n) <= 1, 1);
    chk("rx_data", rx_data, exp_rxd);
    if (pend) begin
      m_t = cyc - p_e0;
      m_ne = m_t / p_h - 1;
      if (m_ne < 0) m_ne = 0;
      if (m_ne > 2 * W) m_ne = 2 * W;
      chk("sclk", spi_sclk, p_cpol ^ m_ne[0]);
      if (!p_cpha) begin
        m_idx = W - 1 - ((m_ne / 2 < W - 1) ? m_ne / 2 : W - 1);
      end else begin
        m_lead = (m_ne + 1) / 2;
        m_idx = W - ((m_lead > 1) ? m_lead : 1);
      end
      chk("mosi", spi_mosi, p_data[m_idx]);
    end else begin
      chk("sclk_idle", spi_sclk, exp_idle);
      chk("mosi_idle", spi_mosi, 0);
    end

    r_q = reset;
    v_q = tx_valid;
    d_q = tx_data;
    pol_q = cpol;
    pha_q = cpha;
    dv_q = clk_div;
    sel_q = cs_sel;
    hd_q = hold_cs;
    rs_q = resp;
    lb_q = lb;
  end

  // Scoreboard monitor: pops on every rx_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid) begin
      if (sq.size() == 0) begin
        chk("rx_unexpected", 1, 0);
      end else begin
        e = sq.pop_front();
        chk("rx_frame", rx_data, e.d);
        chk("rx_time", cyc, e.t);
      end
    end else if (sq.size() != 0 && sq[0].t < cyc) begin
      chk("rx_missing", 0, 1);
      void'(sq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] r,
                      input logic pol, input logic ph,
                      input logic [DW-1:0] dv, input logic [1:0] sel,
                      input logic hd, input logic lbk);
    int a0;
    int n;
    step();
    tx_data = d;
    resp = r;
    cpol = pol;
    cpha = ph;
    clk_div = dv;
    cs_sel = sel;
    hold_cs = hd;
    lb = lbk;
    tx_valid = 1'b1;
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 500) begin
      step();
      n++;
    end
    tx_valid = 1'b0;
    chk("accept", acc_cnt, a0 + 1);
  endtask

  task automatic wait_idle(input int extra);
    int n;
    n = 0;
    while (pend && n < 2000) begin
      step();
      n++;
    end
    chk("idle_reached", pend, 0);
    repeat (extra) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;
    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    cs_sel = '0;
    cpol = 1'b0;
    cpha = 1'b0;
    clk_div = '0;
    hold_cs = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (3) step();

    send(8'hA5, 8'h00, 0, 0, 0, 0, 0, 1);
    wait_idle(2);
    send(8'h3C, 8'hC3, 1, 1, 2, 0, 0, 0);
    wait_idle(2);
    send(8'h81, 8'h00, 0, 1, 0, 0, 0, 1);
    wait_idle(2);
    send(8'h81, 8'h00, 1, 0, 1, 0, 0, 1);
    wait_idle(2);

    send(8'h6E, 8'h19, 0, 0, 0, 1, 1, 0);
    wait_idle(3);
    send(8'hD2, 8'h4B, 0, 0, 0, 1, 0, 0);
    wait_idle(2);
    send(8'h17, 8'hE8, 1, 0, 1, 1, 1, 0);
    wait_idle(3);
    send(8'h9C, 8'h35, 1, 0, 0, 2, 0, 0);
    wait_idle(2);

    a0 = acc_cnt;
    step();
    tx_data = 8'h11;
    resp = 8'h00;
    cpol = 1'b0;
    cpha = 1'b1;
    clk_div = 8'd0;
    cs_sel = 2'd3;
    hold_cs = 1'b0;
    lb = 1'b1;
    tx_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      n = 0;
      while (acc_cnt < a0 + i && n < 500) begin
        step();
        n++;
      end
      tx_data = tx_data + 8'h33;
    end
    tx_valid = 1'b0;
    chk("held_accepts", acc_cnt - a0, 3);
    wait_idle(2);

    send(8'hC9, 8'h00, 0, 0, 1, 2, 0, 1);
    n = 0;
    while (s_edges < 5 && n < 500) begin
      step();
      n++;
    end
    chk("reach_edge5", s_edges >= 5, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (40) step();
    send(8'h5A, 8'h00, 0, 0, 0, 0, 0, 1);
    wait_idle(2);

    for (int i = 0; i < 20; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
           DW'($urandom_range(0, 3)), 2'($urandom),
           (i == 19) ? 1'b0 : 1'($urandom), 1'($urandom));
      wait_idle($urandom_range(0, 3));
    end

    repeat (4) step();
    chk("sq_empty", sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master with a valid/ready transmit port, run-time SPI mode (CPOL/CPHA), a programmable SCLK divider, DATA_W-bit frames and NUM_CS one-hot chip selects. SCLK is generated from `clk` by a divider and is never a gated copy of `clk`. It sits between a register/bus front end and the board SPI pins, and its job is full-duplex frame exchange. Optional chip-select hold lets consecutive frames form one multi-frame burst.

## Interface
Parameters:
- DATA_W, 8: frame width in bits (≥2), transmitted MSB first.
- NUM_CS, 1: number of chip-select lines (≥1).
- DIV_W, 8: width of `clk_div`.
- CSW: derived, max(1, clog2(NUM_CS)).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tx_valid  in  1  frame request.
- tx_ready  out  1  high only in IDLE; transfer accepted on an edge where tx_valid && tx_ready.
- tx_data  in  DATA_W  frame to send.
- cs_sel  in  CSW  target slave index; values ≥ NUM_CS select no line.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- clk_div  in  DIV_W  SCLK half-period H = clk_div+1 clk cycles.
- hold_cs  in  1  keep CS asserted after this frame.
- rx_valid  out  1  one-cycle pulse, frame received.
- rx_data  out  DATA_W  received frame; holds its value until the next rx_valid.
- busy  out  1  state ≠ IDLE.
- spi_sclk  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.
- spi_cs_n  out  NUM_CS  active-low selects; at most one is low at any time.

## Operation
- cpol, cpha, clk_div, cs_sel, hold_cs and tx_data are captured at acceptance. Input changes during a transfer are ignored.
- FSM states: IDLE → SETUP → SHIFT → HOLD → IDLE. Each state is timed by a half-period counter that counts H cycles.
- IDLE:
  - tx_ready=1 and spi_sclk=captured cpol. Before the first transfer, spi_sclk=0.
  - All spi_cs_n are high unless a held CS is active.
- SETUP, lasting H cycles:
  - spi_cs_n[cs_sel] goes low.
  - spi_mosi = tx_data[DATA_W-1].
  - SCLK stays at idle.
- SHIFT, lasting 2·DATA_W half-periods:
  - spi_sclk toggles at the end of each half-period. Edges k = 1..2·DATA_W; odd k are leading edges, even k are trailing edges.
  - cpha=0: spi_miso is sampled on odd edges. spi_mosi advances to the next bit on even edges 2..2·DATA_W−2.
  - cpha=1: spi_mosi is driven with bit DATA_W−j on leading edge j. spi_miso is sampled on even edges.
  - Sampling means shifting spi_miso into the LSB of the receive shift register.
- HOLD, lasting H cycles: CS stays asserted and SCLK is at idle. At the end of HOLD:
  - rx_data ← shift register.
  - rx_valid pulses.
  - If hold_cs=0, CS is released.
  - The FSM returns to IDLE.
- Held CS:
  - Stays low through IDLE until a later frame completes with hold_cs=0.
  - If the next accepted frame has a different cs_sel, the held line goes high on the acceptance edge and the new line goes low in the same cycle.
- Reset mid-transfer: on the next edge all outputs take their reset values. The frame is abandoned and no rx_valid is generated.
- Reset values: tx_ready=1, busy=0, rx_valid=0, rx_data=0, spi_sclk=0, spi_mosi=0, spi_cs_n=all 1.
- All outputs are registered. spi_mosi goes to 0 on return to IDLE.

## Timing
- Acceptance edge is E0. SETUP covers E0+1..E0+H. SHIFT covers the next 2·DATA_W·H cycles. HOLD covers the next H cycles.
- rx_valid is high in the cycle following edge E0+(2·DATA_W+2)·H. tx_ready rises on the same edge.
- Back-to-back frames can be accepted in that same rx_valid cycle, giving a period of (2·DATA_W+2)·H+1 cycles.
- DATA_W=8, clk_div=0: rx_valid at E0+18. The SCLK period is 2 clk cycles.
- The fastest SCLK is clk/2.
- spi_miso is sampled on the clk edge that produces the sampling SCLK edge. Slaves must present data at least one clk cycle before that edge.

## Test plan
- Mode 0, DATA_W=8, clk_div=0, tx_data=0xA5, spi_miso looped to spi_mosi -> 8 rising SCLK edges, rx_data=0xA5, rx_valid at E0+18, spi_cs_n[0] low from E0+1 until rx_valid.
- Mode 3, clk_div=2, tx_data=0x3C, slave model returns 0xC3 -> SCLK idles high with a 6-cycle period, mosi changes only on falling edges, rx_data=0xC3, rx_valid at E0+54.
- Mode 1 and mode 2, 0x81, loopback -> rx_data=0x81 in each mode, with sample and shift edges per the cpha rules.
- NUM_CS=4: frame to cs_sel=1 with hold_cs=1, then cs_sel=1 with hold_cs=0 -> spi_cs_n[1] stays low continuously across both frames, then goes high. Repeat with the second frame on cs_sel=2 -> cs_n[1] rises and cs_n[2] falls on the same edge.
- tx_valid held high for 3 frames with changing tx_data -> exactly 3 acceptances and busy continuous except for the single-cycle gaps.
- Assert reset at edge 5 of SHIFT -> next cycle all outputs at reset values, no rx_valid. A following 0x5A frame completes correctly.
